// File: rtl/spi_rom_loader_pkg.sv
// Shared types and constants for the SPI flash to SRAM boot loader.
package spi_rom_loader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CMD  = 3'd1,
      ADDR = 3'd2,
      DATA = 3'd3,
      FIN  = 3'd4
   } loader_state_t;

   localparam logic [7:0] SPI_CMD_READ = 8'h03;

endpackage

// File: rtl/spi_rom_loader_shift8.sv
// SPI mode-0 byte shifter: phase counter, MSB-first MOSI shifter and MISO
// assembler. Bytes chain back to back without gaps while 'more' is held.
module spi_rom_loader_shift8 #(
   parameter int unsigned SCK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       more,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sck,
   output logic       mosi,
   output logic       running,
   output logic       byte_end_c,
   output logic [7:0] rx_c
);

   localparam int unsigned PW = $clog2(SCK_DIV);
   localparam logic [PW-1:0] LAST_PH  = PW'(SCK_DIV - 1);
   localparam logic [PW-1:0] HALF_PH  = PW'(SCK_DIV / 2);
   localparam logic [PW-1:0] PRE_HALF = PW'(SCK_DIV / 2 - 1);

   logic [PW-1:0] phase;
   logic [2:0]    bit_idx;
   logic [7:0]    tx_sreg;
   logic [7:0]    rx_sreg;

   // Last phase of bit 7: the byte is complete at the end of this cycle.
   assign byte_end_c = running && (phase == LAST_PH) && (bit_idx == 3'd7);

   // Include the bit being sampled this cycle when sample and byte end coincide.
   assign rx_c = (phase == HALF_PH) ? {rx_sreg[6:0], miso} : rx_sreg;

   // Phase/bit sequencing, MOSI launch at phase 0, MISO capture at first high phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         running <= 1'b0;
         phase   <= '0;
         bit_idx <= 3'd0;
         tx_sreg <= 8'h00;
         rx_sreg <= 8'h00;
         sck     <= 1'b0;
         mosi    <= 1'b0;
      end else if (load) begin
         running <= 1'b1;
         phase   <= '0;
         bit_idx <= 3'd0;
         tx_sreg <= {tx_byte[6:0], 1'b0};
         mosi    <= tx_byte[7];
         sck     <= 1'b0;
      end else if (running) begin
         if (phase == HALF_PH) begin
            rx_sreg <= {rx_sreg[6:0], miso};
         end
         if (phase == LAST_PH) begin
            phase <= '0;
            sck   <= 1'b0;
            if (bit_idx == 3'd7) begin
               bit_idx <= 3'd0;
               if (more) begin
                  tx_sreg <= {tx_byte[6:0], 1'b0};
                  mosi    <= tx_byte[7];
               end else begin
                  running <= 1'b0;
                  mosi    <= 1'b0;
               end
            end else begin
               bit_idx <= bit_idx + 3'd1;
               mosi    <= tx_sreg[7];
               tx_sreg <= {tx_sreg[6:0], 1'b0};
            end
         end else begin
            phase <= phase + PW'(1);
            if (phase == PRE_HALF) begin
               sck <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_rom_loader.sv
// Boot loader: issues a flash READ at FLASH_OFFSET and streams LENGTH bytes
// into the SRAM initializer port, then signals done.
module spi_rom_loader
   import spi_rom_loader_pkg::*;
#(
   parameter logic [23:0] FLASH_OFFSET = 24'h13256,
   parameter int unsigned LENGTH       = 32'h10000,
   parameter int unsigned SCK_DIV      = 4
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        start,
   output logic        flash_cs_n,
   output logic        flash_sck,
   output logic        flash_mosi,
   input  logic        flash_miso,
   output logic [16:0] ram_address,
   output logic [7:0]  ram_data,
   output logic        ram_wren,
   output logic        busy,
   output logic        done
);

   localparam logic [16:0] LAST_ADDR = 17'(LENGTH - 1);

   loader_state_t state, state_nxt;
   logic [1:0]    addr_idx, addr_idx_nxt;
   logic          cs_n_nxt, busy_nxt, done_nxt, wren_nxt;
   logic [16:0]   address_nxt;
   logic [7:0]    data_nxt;

   logic          load_c, more_c, running, byte_end_c;
   logic [7:0]    tx_c, rx_c;

   spi_rom_loader_shift8 #(
      .SCK_DIV (SCK_DIV)
   ) u_shift (
      .clk        (clk28),
      .rst_n      (rst_n),
      .load       (load_c),
      .more       (more_c),
      .tx_byte    (tx_c),
      .miso       (flash_miso),
      .sck        (flash_sck),
      .mosi       (flash_mosi),
      .running    (running),
      .byte_end_c (byte_end_c),
      .rx_c       (rx_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_idx    <= 2'd0;
         flash_cs_n  <= 1'b1;
         busy        <= 1'b0;
         done        <= 1'b0;
         ram_address <= 17'd0;
         ram_data    <= 8'h00;
         ram_wren    <= 1'b0;
      end else begin
         state       <= state_nxt;
         addr_idx    <= addr_idx_nxt;
         flash_cs_n  <= cs_n_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;
         ram_address <= address_nxt;
         ram_data    <= data_nxt;
         ram_wren    <= wren_nxt;
      end
   end

   // Byte sequencing: command, three address bytes, then LENGTH data bytes.
   always_comb begin
      state_nxt    = state;
      addr_idx_nxt = addr_idx;
      cs_n_nxt     = flash_cs_n;
      busy_nxt     = busy;
      done_nxt     = done;
      address_nxt  = ram_address;
      data_nxt     = ram_data;
      wren_nxt     = 1'b0;
      load_c       = 1'b0;
      more_c       = 1'b0;
      tx_c         = 8'h00;

      unique case (state)
         IDLE, FIN: begin
            if (start) begin
               state_nxt   = CMD;
               cs_n_nxt    = 1'b0;
               busy_nxt    = 1'b1;
               done_nxt    = 1'b0;
               address_nxt = 17'd0;
            end
         end
         CMD: begin
            // First cycle kicks the shifter with the command; afterwards the
            // next byte presented is the top address byte.
            load_c = !running;
            more_c = 1'b1;
            tx_c   = running ? FLASH_OFFSET[23:16] : SPI_CMD_READ;
            if (byte_end_c) begin
               state_nxt    = ADDR;
               addr_idx_nxt = 2'd0;
            end
         end
         ADDR: begin
            more_c = 1'b1;
            case (addr_idx)
               2'd0:    tx_c = FLASH_OFFSET[15:8];
               2'd1:    tx_c = FLASH_OFFSET[7:0];
               default: tx_c = 8'h00;
            endcase
            if (byte_end_c) begin
               if (addr_idx == 2'd2) begin
                  state_nxt = DATA;
               end else begin
                  addr_idx_nxt = addr_idx + 2'd1;
               end
            end
         end
         DATA: begin
            // Stop the clock after the final byte so no extra SCK edges go out.
            more_c = (ram_address != LAST_ADDR);
            if (byte_end_c) begin
               data_nxt = rx_c;
               wren_nxt = 1'b1;
            end
            if (ram_wren) begin
               if (ram_address == LAST_ADDR) begin
                  state_nxt = FIN;
                  cs_n_nxt  = 1'b1;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end else begin
                  address_nxt = ram_address + 17'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_spi_rom_loader.sv
// Directed bench for spi_rom_loader with a behavioural SPI flash per instance.
module tb_spi_rom_loader;

   logic clk28 = 1'b0;
   always #5 clk28 = ~clk28;

   logic        rst_n, start0, start1;
   logic        cs0, sck0, mosi0, miso0, wren0, busy0, done0;
   logic        cs1, sck1, mosi1, miso1, wren1, busy1, done1;
   logic [16:0] addr0, addr1;
   logic [7:0]  data0, data1;

   int n_checks = 0;
   int n_fail   = 0;

   spi_rom_loader #(.FLASH_OFFSET(24'h13256), .LENGTH(16), .SCK_DIV(4)) dut0 (
      .clk28(clk28), .rst_n(rst_n), .start(start0),
      .flash_cs_n(cs0), .flash_sck(sck0), .flash_mosi(mosi0), .flash_miso(miso0),
      .ram_address(addr0), .ram_data(data0), .ram_wren(wren0),
      .busy(busy0), .done(done0));

   spi_rom_loader #(.FLASH_OFFSET(24'h13256), .LENGTH(1), .SCK_DIV(4)) dut1 (
      .clk28(clk28), .rst_n(rst_n), .start(start1),
      .flash_cs_n(cs1), .flash_sck(sck1), .flash_mosi(mosi1), .flash_miso(miso1),
      .ram_address(addr1), .ram_data(data1), .ram_wren(wren1),
      .busy(busy1), .done(done1));

   // Flash returns addr[7:0] at each address; bit n counts SCK rising edges.
   function automatic logic flash_bit(input int n, input logic [31:0] cmd);
      int j;
      logic [7:0] b;
      if (n < 32) return 1'b0;
      j = n - 32;
      b = cmd[7:0] + 8'(j / 8);
      return b[7 - (j % 8)];
   endfunction

   int          fl0_cnt, fl0_out, fl0_hi, fl1_cnt, fl1_out, fl1_hi;
   logic [31:0] fl0_cmd, fl1_cmd;

   always @(posedge sck0 or posedge cs0) begin
      if (cs0) fl0_cnt <= 0;
      else begin
         if (fl0_cnt < 32) fl0_cmd <= {fl0_cmd[30:0], mosi0};
         else if (mosi0) fl0_hi <= fl0_hi + 1;
         fl0_cnt <= fl0_cnt + 1;
      end
   end
   always @(negedge sck0) fl0_out <= fl0_cnt;
   assign miso0 = flash_bit(fl0_out, fl0_cmd);

   always @(posedge sck1 or posedge cs1) begin
      if (cs1) fl1_cnt <= 0;
      else begin
         if (fl1_cnt < 32) fl1_cmd <= {fl1_cmd[30:0], mosi1};
         else if (mosi1) fl1_hi <= fl1_hi + 1;
         fl1_cnt <= fl1_cnt + 1;
      end
   end
   always @(negedge sck1) fl1_out <= fl1_cnt;
   assign miso1 = flash_bit(fl1_out, fl1_cmd);

   // Cycle counter and output monitors (sampled mid-cycle).
   int   cyc = 0;
   int   w0_addr[$], w0_data[$], w0_cyc[$], rise0[$], fall0[$];
   int   w1_addr[$], w1_data[$];
   int   rise1_n = 0, glitch0 = 0;
   logic sck0_d = 1'b0, sck1_d = 1'b0;

   always @(posedge clk28) cyc <= cyc + 1;

   always @(negedge clk28) begin
      sck0_d <= sck0;
      sck1_d <= sck1;
      if (wren0 === 1'b1) begin
         w0_addr.push_back(int'(addr0));
         w0_data.push_back(int'(data0));
         w0_cyc.push_back(cyc);
      end
      if (wren1 === 1'b1) begin
         w1_addr.push_back(int'(addr1));
         w1_data.push_back(int'(data1));
      end
      if (sck0 === 1'b1 && sck0_d === 1'b0) rise0.push_back(cyc);
      if (sck0 === 1'b0 && sck0_d === 1'b1) fall0.push_back(cyc);
      if (sck1 === 1'b1 && sck1_d === 1'b0) rise1_n <= rise1_n + 1;
      if (busy0 === 1'b1 && cs0 === 1'b1) glitch0 <= glitch0 + 1;
   end

   task automatic pulse_start0(output int sc);
      @(negedge clk28) start0 = 1'b1;
      @(negedge clk28);
      sc     = cyc;
      start0 = 1'b0;
   endtask

   task automatic wait_done0(output bit ok);
      int k = 0;
      while (done0 !== 1'b1 && k < 5000) begin
         @(negedge clk28);
         k++;
      end
      ok = (done0 === 1'b1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
      repeat (3) @(negedge clk28);
      n_checks++; if (cs0 !== 1'b1)     begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs0); end
      n_checks++; if (sck0 !== 1'b0)    begin n_fail++; $display("FAIL reset_sck: got %b want 0", sck0); end
      n_checks++; if (mosi0 !== 1'b0)   begin n_fail++; $display("FAIL reset_mosi: got %b want 0", mosi0); end
      n_checks++; if (addr0 !== 17'd0)  begin n_fail++; $display("FAIL reset_address: got %h want 0", addr0); end
      n_checks++; if (data0 !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h want 0", data0); end
      n_checks++; if (wren0 !== 1'b0)   begin n_fail++; $display("FAIL reset_wren: got %b want 0", wren0); end
      n_checks++; if (busy0 !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy0); end
      n_checks++; if (done0 !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done0); end
      n_checks++; if (cs1 !== 1'b1 || done1 !== 1'b0) begin n_fail++; $display("FAIL reset_len1: cs_n=%b done=%b want 1/0", cs1, done1); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk28);
   endtask

   task automatic test_full_load();
      int wb, rb, fb, hb, sc, n;
      bit ok;
      wb = w0_addr.size(); rb = rise0.size(); fb = fall0.size(); hb = fl0_hi;
      pulse_start0(sc);
      n_checks++; if (busy0 !== 1'b1 || cs0 !== 1'b0) begin n_fail++; $display("FAIL start_accept: busy=%b cs_n=%b want 1/0", busy0, cs0); end
      wait_done0(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL full_load_timeout: done=%b want 1", done0); end
      n_checks++; if (fl0_cmd !== 32'h03013256) begin n_fail++; $display("FAIL cmd_addr_bits: got %h want 03013256", fl0_cmd); end
      n = w0_addr.size() - wb;
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL write_count: got %0d want 16", n); end
      for (int i = 0; i < 16 && i < n; i++) begin
         n_checks++;
         if (w0_addr[wb+i] !== i || w0_data[wb+i] !== 8'h56 + i) begin
            n_fail++; $display("FAIL write_%0d: got addr %0h data %0h want %0h/%0h", i, w0_addr[wb+i], w0_data[wb+i], i, 8'h56 + i);
         end
      end
      n_checks++; if (n > 0 && w0_cyc[wb] - sc !== 161) begin n_fail++; $display("FAIL first_wren_latency: got %0d want 161", w0_cyc[wb] - sc); end
      for (int i = 0; i + 1 < n; i++) begin
         n_checks++;
         if (w0_cyc[wb+i+1] - w0_cyc[wb+i] !== 32) begin
            n_fail++; $display("FAIL wren_spacing_%0d: got %0d want 32", i, w0_cyc[wb+i+1] - w0_cyc[wb+i]);
         end
      end
      n_checks++; if (rise0.size() - rb !== 160) begin n_fail++; $display("FAIL sck_rise_count: got %0d want 160", rise0.size() - rb); end
      n_checks++; if (rise0.size() > rb && rise0[rb] - sc !== 3) begin n_fail++; $display("FAIL first_sck_rise: got %0d want 3", rise0[rb] - sc); end
      for (int i = 0; i < 8 && rb + i + 1 < rise0.size() && fb + i < fall0.size(); i++) begin
         n_checks++;
         if (rise0[rb+i+1] - rise0[rb+i] !== 4 || fall0[fb+i] - rise0[rb+i] !== 2) begin
            n_fail++; $display("FAIL sck_shape_%0d: period %0d high %0d want 4/2", i, rise0[rb+i+1] - rise0[rb+i], fall0[fb+i] - rise0[rb+i]);
         end
      end
      n_checks++; if (fl0_hi !== hb) begin n_fail++; $display("FAIL mosi_in_data: got %0d high bits want 0", fl0_hi - hb); end
      @(negedge clk28);
      n_checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || cs0 !== 1'b1 || sck0 !== 1'b0) begin
         n_fail++; $display("FAIL fin_outputs: done=%b busy=%b cs_n=%b sck=%b want 1/0/1/0", done0, busy0, cs0, sck0);
      end
   endtask

   task automatic test_start_ignored();
      int wb, gb, sc, n;
      bit ok;
      wb = w0_addr.size(); gb = glitch0;
      pulse_start0(sc);
      repeat (48) @(negedge clk28);
      start0 = 1'b1;
      @(negedge clk28);
      start0 = 1'b0;
      wait_done0(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL ignore_timeout: done=%b want 1", done0); end
      n = w0_addr.size() - wb;
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL ignore_write_count: got %0d want 16", n); end
      for (int i = 0; i < 16 && i < n; i++) begin
         n_checks++;
         if (w0_addr[wb+i] !== i || w0_data[wb+i] !== 8'h56 + i) begin
            n_fail++; $display("FAIL ignore_write_%0d: got %0h/%0h want %0h/%0h", i, w0_addr[wb+i], w0_data[wb+i], i, 8'h56 + i);
         end
      end
      n_checks++; if (n > 0 && w0_cyc[wb] - sc !== 161) begin n_fail++; $display("FAIL ignore_latency: got %0d want 161", w0_cyc[wb] - sc); end
      n_checks++; if (glitch0 !== gb) begin n_fail++; $display("FAIL ignore_cs_glitch: got %0d want 0", glitch0 - gb); end
   endtask

   task automatic test_restart_in_fin();
      int wb, sc, n;
      bit ok;
      wb = w0_addr.size();
      n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL restart_precond_done: got %b want 1", done0); end
      pulse_start0(sc);
      n_checks++; if (done0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL restart_edge: done=%b busy=%b want 0/1", done0, busy0); end
      wait_done0(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL restart_timeout: done=%b want 1", done0); end
      n = w0_addr.size() - wb;
      n_checks++; if (n !== 16) begin n_fail++; $display("FAIL restart_write_count: got %0d want 16", n); end
      for (int i = 0; i < 16 && i < n; i++) begin
         n_checks++;
         if (w0_addr[wb+i] !== i || w0_data[wb+i] !== 8'h56 + i) begin
            n_fail++; $display("FAIL restart_write_%0d: got %0h/%0h want %0h/%0h", i, w0_addr[wb+i], w0_data[wb+i], i, 8'h56 + i);
         end
      end
   endtask

   task automatic test_reset_abort();
      int wb, sc, n, k;
      bit ok;
      wb = w0_addr.size();
      pulse_start0(sc);
      k = 0;
      while (w0_addr.size() - wb < 5 && k < 2000) begin
         @(negedge clk28);
         k++;
      end
      n_checks++; if (w0_addr.size() - wb !== 5) begin n_fail++; $display("FAIL abort_reach_byte5: got %0d writes want 5", w0_addr.size() - wb); end
      repeat (10) @(negedge clk28);
      rst_n = 1'b0;
      @(negedge clk28);
      n_checks++; if (cs0 !== 1'b1 || sck0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || wren0 !== 1'b0) begin
         n_fail++; $display("FAIL abort_edge: cs_n=%b sck=%b busy=%b done=%b wren=%b want 1/0/0/0/0", cs0, sck0, busy0, done0, wren0);
      end
      repeat (3) @(negedge clk28);
      rst_n = 1'b1;
      repeat (100) @(negedge clk28);
      n_checks++; if (w0_addr.size() - wb !== 5 || done0 !== 1'b0) begin
         n_fail++; $display("FAIL abort_no_more_writes: got %0d writes done=%b want 5/0", w0_addr.size() - wb, done0);
      end
      wb = w0_addr.size();
      pulse_start0(sc);
      wait_done0(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reload_timeout: done=%b want 1", done0); end
      n = w0_addr.size() - wb;
      n_checks++; if (n !== 16 || fl0_cmd !== 32'h03013256) begin n_fail++; $display("FAIL abort_reload: got %0d writes cmd %h want 16/03013256", n, fl0_cmd); end
      for (int i = 0; i < 16 && i < n; i++) begin
         n_checks++;
         if (w0_addr[wb+i] !== i || w0_data[wb+i] !== 8'h56 + i) begin
            n_fail++; $display("FAIL abort_reload_write_%0d: got %0h/%0h want %0h/%0h", i, w0_addr[wb+i], w0_data[wb+i], i, 8'h56 + i);
         end
      end
   endtask

   task automatic test_length_one();
      int wb, rb, k;
      wb = w1_addr.size(); rb = rise1_n;
      @(negedge clk28) start1 = 1'b1;
      @(negedge clk28) start1 = 1'b0;
      k = 0;
      while (done1 !== 1'b1 && k < 1000) begin
         @(negedge clk28);
         k++;
      end
      n_checks++; if (done1 !== 1'b1) begin n_fail++; $display("FAIL len1_timeout: done=%b want 1", done1); end
      repeat (20) @(negedge clk28);
      n_checks++; if (w1_addr.size() - wb !== 1) begin n_fail++; $display("FAIL len1_write_count: got %0d want 1", w1_addr.size() - wb); end
      n_checks++; if (w1_addr.size() > wb && (w1_addr[wb] !== 0 || w1_data[wb] !== 8'h56)) begin
         n_fail++; $display("FAIL len1_write: got %0h/%0h want 0/56", w1_addr[wb], w1_data[wb]);
      end
      n_checks++; if (rise1_n - rb !== 40) begin n_fail++; $display("FAIL len1_sck_edges: got %0d want 40", rise1_n - rb); end
      n_checks++; if (cs1 !== 1'b1 || busy1 !== 1'b0 || sck1 !== 1'b0 || fl1_hi !== 0) begin
         n_fail++; $display("FAIL len1_fin: cs_n=%b busy=%b sck=%b mosi_hi=%0d want 1/0/0/0", cs1, busy1, sck1, fl1_hi);
      end
   endtask

   initial begin
      test_reset();
      test_full_load();
      test_start_ignored();
      test_restart_in_fin();
      test_reset_abort();
      test_length_one();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_rom_loader.md
Name: spi_rom_loader

Overview:
- Boot-time loader that streams the ROM image from the configuration SPI flash into external SRAM before the CPU is released from reset.
- Sits upstream of the memory controller. Drives its initializer write port (address, data, write enable) and the init-done indication consumed by the CPU controller.
- Replaces the ASMI-based path with a direct SPI master, so the boot ROM image can live at any flash offset.

Parameters:
- FLASH_OFFSET, 24'h13256: flash byte address of the first image byte.
- LENGTH, 17'h10000: number of bytes to copy, 1..2^17.
- SCK_DIV, 4: clk28 cycles per SCK period. Must be even and >= 2.

Ports:
- clk28  in  1  system clock, 28 MHz
- rst_n  in  1  synchronous reset, active-low
- start  in  1  single-cycle load request
- flash_cs_n  out  1  SPI chip select
- flash_sck  out  1  SPI clock, mode 0
- flash_mosi  out  1  SPI data to flash
- flash_miso  in  1  SPI data from flash
- ram_address  out  17  SRAM write address
- ram_data  out  8  SRAM write data
- ram_wren  out  1  one-cycle write strobe
- busy  out  1  load in progress
- done  out  1  sticky: load completed

Behaviour:
- Clocking and reset: one clock, clk28. rst_n is synchronous and active-low. Everything is sampled on the rising edge of clk28.
- Reset values: flash_cs_n=1, flash_sck=0, flash_mosi=0, ram_address=0, ram_data=0, ram_wren=0, busy=0, done=0, state=IDLE. Reset asserted mid-transfer aborts on that edge: CS released, no further writes, done stays 0.
- States: IDLE, CMD, ADDR, DATA, FIN.
  - IDLE: start=1 -> CMD. On the same edge: flash_cs_n<=0, busy<=1, done<=0, byte counter<=0, ram_address<=0.
  - CMD: shifts out 8'h03, MSB first, then -> ADDR.
  - ADDR: shifts out FLASH_OFFSET[23:0], MSB first, then -> DATA.
  - DATA: shifts in bytes continuously with CS held low, no re-addressing.
  - FIN: flash_cs_n=1, busy=0, done=1. Stays here until start or reset. start in FIN restarts a full load exactly as from IDLE.
- start while busy is ignored.
- Bit timing, phase counter p = 0..SCK_DIV-1:
  - flash_mosi updates at p=0. flash_sck=0 for p < SCK_DIV/2 and 1 otherwise.
  - flash_miso is sampled at the first high cycle (p=SCK_DIV/2).
  - Each bit lasts SCK_DIV cycles. The first bit starts the cycle after start is accepted.
- Byte completion: on the cycle following the final phase of bit 7 of a DATA byte:
  - ram_data = assembled byte, ram_wren=1 for exactly one cycle.
  - ram_address holds the byte index during the strobe and increments the cycle after.
- Timing with SCK_DIV=4: the first ram_wren occurs 161 cycles after the start edge. Subsequent strobes come every 32 cycles.
- End of load: after the write of byte LENGTH-1, on the next edge: flash_cs_n=1, flash_sck=0, -> FIN. No extra SCK edges are issued.
- LENGTH=1: exactly one write, at address 0.
- flash_mosi is held 0 during DATA.
- No write back-pressure: the memory controller gives the initializer exclusive SRAM access while busy.
- Flash address overflow past 2^24 is not checked; the flash device wraps.

Decomposition:
- Shared package gets the state typedef (loader_state_t) and the read command constant SPI_CMD_READ=8'h03.
- One natural sub-module, spi_shift8: a phase counter plus 8-bit MOSI/MISO shift register with a byte_done pulse. The top FSM sequences bytes through it (1 cmd byte, 3 address bytes, then LENGTH data bytes).

Test Plan:
- Full load, LENGTH=16, FLASH_OFFSET=24'h13256, flash model returning addr[7:0] -> first 32 SCK rising edges carry bits 03_01_32_56. Writes are addresses 0..15 with data 56..65. done=1, busy=0, cs_n=1 afterwards.
- SCK_DIV=4 timing -> first ram_wren exactly 161 cycles after start. Strobe spacing is 32 cycles. Each strobe is one cycle wide. SCK period is 4 cycles with 50% duty.
- start pulsed at cycle 50 of an active load -> ignored: write count and order unchanged, no CS glitch.
- rst_n low during byte 5 -> next edge shows cs_n=1, sck=0, busy=0, done=0, no further wren. A following start performs a clean full load.
- LENGTH=1 -> single write, addr 0, data 56. Total 40 SCK edges, then FIN.
- start in FIN -> done clears on that edge and the load repeats with identical write sequence.
